// File: rtl/scc_4lc_pkg.sv
// SCC 4LC code constants, error classification and parity-check columns.
// Codeword layout: [70:64] check bits, [63:0] message.
package scc_4lc_pkg;
  localparam int CW_W  = 71;
  localparam int MSG_W = 64;
  localparam int CHK_W = CW_W - MSG_W;

  typedef enum logic [1:0] {
    ERR_NE   = 2'b00,
    ERR_CE   = 2'b01,
    ERR_DUE  = 2'b10,
    ERR_RSVD = 2'b11
  } err_type_e;

  // Reserved encodings are treated as uncorrectable.
  function automatic logic is_due(err_type_e e);
    return (e == ERR_DUE) || (e == ERR_RSVD);
  endfunction

  // Check bit j owns column 1<<j.
  // Message bit i owns 0x3F when i is 0, otherwise 0x40|i.
  // All 71 columns are distinct and non-zero.
  function automatic logic [CHK_W-1:0] h_col(int i);
    return (i == 0) ? CHK_W'(7'h3F) : CHK_W'(64 + i);
  endfunction
endpackage

// File: rtl/scc_decode_scheduler_if.sv
// Request/response bus of the shared decode scheduler.
interface scc_decode_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 8
);
  import scc_4lc_pkg::*;
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*CW_W-1:0] req_codeword;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [TAG_W-1:0]        rsp_tag;
  logic [MSG_W-1:0]        rsp_message;
  logic [1:0]              rsp_error_type;

  modport master (
    output req_valid, req_codeword, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_message, rsp_error_type
  );
  modport slave (
    input  req_valid, req_codeword, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_message, rsp_error_type
  );
endinterface

// File: rtl/scc_4lc_decoder.sv
// Combinational SCC 4LC decoder: syndrome, single-bit correction, error class.
module scc_4lc_decoder
  import scc_4lc_pkg::*;
(
  input  logic [CW_W-1:0]  codeword,
  output logic [MSG_W-1:0] message,
  output err_type_e        error_type
);
  logic [CHK_W-1:0] syndrome;
  logic             hit;

  always_comb begin
    syndrome = codeword[CW_W-1:MSG_W];
    for (int i = 0; i < MSG_W; i++)
      if (codeword[i]) syndrome = syndrome ^ h_col(i);
  end

  // A syndrome that matches no column is an uncorrectable multi-bit error.
  always_comb begin
    message    = codeword[MSG_W-1:0];
    hit        = 1'b0;
    error_type = ERR_DUE;
    for (int i = 0; i < MSG_W; i++)
      if (syndrome == h_col(i)) begin
        message[i] = ~message[i];
        hit        = 1'b1;
      end
    for (int j = 0; j < CHK_W; j++)
      if (syndrome == CHK_W'(1 << j)) hit = 1'b1;
    if (syndrome == '0) error_type = ERR_NE;
    else if (hit)       error_type = ERR_CE;
  end
endmodule

// File: rtl/scc_rr_arbiter.sv
// Round-robin arbiter. The search starts one past the last accepted requester.
module scc_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);
  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   idx;
  logic            found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (en && !found && req[idx[ID_W-1:0]]) begin
        found                 = 1'b1;
        grant[idx[ID_W-1:0]]  = 1'b1;
        grant_id              = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk)
    if (rst)          ptr <= '0;
    else if (advance) ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
endmodule

// File: rtl/scc_decode_scheduler.sv
// Shares one SCC 4LC decoder among NUM_REQ requesters through a two-stage
// valid/ready pipeline. Also keeps saturating CE/DUE counters and a sticky DUE flag.
module scc_decode_scheduler
  import scc_4lc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  scc_decode_scheduler_if.slave  bus,
  input  logic                   stat_clear,
  output logic [CNT_W-1:0]       ce_count,
  output logic [CNT_W-1:0]       due_count,
  output logic                   due_flag
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [2:1]         vld_pipe;
  logic [CW_W-1:0]    s1_cw;
  logic [TAG_W-1:0]   s1_tag, s2_tag;
  logic [ID_W-1:0]    s1_id, s2_id;
  logic [MSG_W-1:0]   dec_msg, s2_msg;
  err_type_e          dec_err, s2_err;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               s1_free, s2_free, req_hs, rsp_hs;

  assign s2_free = !vld_pipe[2] || bus.rsp_ready;
  assign s1_free = !vld_pipe[1] || s2_free;
  assign req_hs  = |grant;  // grant is already qualified by req_valid
  assign rsp_hs  = vld_pipe[2] && bus.rsp_ready;

  assign bus.req_ready      = grant;
  assign bus.rsp_valid      = vld_pipe[2];
  assign bus.rsp_id         = s2_id;
  assign bus.rsp_tag        = s2_tag;
  assign bus.rsp_message    = s2_msg;
  assign bus.rsp_error_type = s2_err;

  scc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.req_valid),
    .en       (s1_free && !rst),
    .advance  (req_hs),
    .grant    (grant),
    .grant_id (grant_id)
  );

  scc_4lc_decoder u_dec (
    .codeword   (s1_cw),
    .message    (dec_msg),
    .error_type (dec_err)
  );

  always_ff @(posedge clk)
    if (rst) begin
      vld_pipe <= '0;
      s1_cw    <= '0;
      s1_tag   <= '0;
      s1_id    <= '0;
      s2_tag   <= '0;
      s2_id    <= '0;
      s2_msg   <= '0;
      s2_err   <= ERR_NE;
    end else begin
      if (s1_free) begin
        vld_pipe[1] <= req_hs;
        if (req_hs) begin
          s1_cw  <= bus.req_codeword[grant_id*CW_W +: CW_W];
          s1_tag <= bus.req_tag[grant_id*TAG_W +: TAG_W];
          s1_id  <= grant_id;
        end
      end
      if (s2_free) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          s2_tag <= s1_tag;
          s2_id  <= s1_id;
          s2_msg <= dec_msg;
          s2_err <= dec_err;
        end
      end
    end

  // Count on the output handshake so a stalled response is counted once.
  always_ff @(posedge clk)
    if (rst || stat_clear) begin
      ce_count  <= '0;
      due_count <= '0;
      due_flag  <= 1'b0;
    end else if (rsp_hs) begin
      if (s2_err == ERR_CE && ce_count != '1) ce_count <= ce_count + 1'b1;
      if (is_due(s2_err)) begin
        due_flag <= 1'b1;
        if (due_count != '1) due_count <= due_count + 1'b1;
      end
    end
endmodule
